// File: rtl/vga_screen_scanner_if.sv
// vga_screen_scanner_if: screen-memory lookup and pixel-output bundle of the VGA tile scanner
interface vga_screen_scanner_if;
    logic [1:0]  characterCode;
    logic [10:0] screenAddr;
    logic [9:0]  bitmapAddr;
    logic        hsync;
    logic        vsync;
    logic        activevideo;
    logic        pixel_tick;
    modport master (
        input  characterCode,
        output screenAddr, bitmapAddr, hsync, vsync, activevideo, pixel_tick
    );
    modport slave (
        output characterCode,
        input  screenAddr, bitmapAddr, hsync, vsync, activevideo, pixel_tick
    );
endinterface

// File: rtl/vga_screen_scanner.sv
// vga_screen_scanner: VGA timing, tile screen-address generation and a one-pixel bitmap-address stage
module vga_screen_scanner #(
    parameter int CLKDIV = 4,
    parameter int HPIX   = 640,
    parameter int HFP    = 16,
    parameter int HSW    = 96,
    parameter int HBP    = 48,
    parameter int VPIX   = 480,
    parameter int VFP    = 10,
    parameter int VSW    = 2,
    parameter int VBP    = 33,
    parameter int COLS   = 40
) (
    input logic                  clk,
    input logic                  reset,
    vga_screen_scanner_if.master bus
);
    localparam int HT = HPIX + HFP + HSW + HBP;
    localparam int VT = VPIX + VFP + VSW + VBP;
    logic [1:0]  div_q, div_d;
    logic [9:0]  x_q, x_d, y_q, y_d, bmp_q, bmp_d;
    logic        hs_q, hs_d, vs_q, vs_d, av_q, av_d;
    logic        tick, x_end, y_end, vis0, hs0, vs0;
    logic [10:0] row, col;
    always_comb begin
        tick  = div_q == 2'(CLKDIV - 1);
        x_end = x_q == 10'(HT - 1);
        y_end = y_q == 10'(VT - 1);
        div_d = tick ? 2'd0 : div_q + 2'd1;
        x_d   = !tick ? x_q : x_end ? 10'd0 : x_q + 10'd1;
        y_d   = !(tick && x_end) ? y_q : y_end ? 10'd0 : y_q + 10'd1;
        vis0  = (x_q < 10'(HPIX)) && (y_q < 10'(VPIX));
        hs0   = !(x_q >= 10'(HPIX + HFP) && x_q <= 10'(HPIX + HFP + HSW - 1));
        vs0   = !(y_q >= 10'(VPIX + VFP) && y_q <= 10'(VPIX + VFP + VSW - 1));
        row   = {5'd0, y_q[9:4]};
        col   = {5'd0, x_q[9:4]};
        bmp_d = tick ? {bus.characterCode, y_q[3:0], x_q[3:0]} : bmp_q;
        hs_d  = tick ? hs0 : hs_q;
        vs_d  = tick ? vs0 : vs_q;
        av_d  = tick ? vis0 : av_q;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q <= 2'd0;
            x_q   <= 10'd0;
            y_q   <= 10'd0;
            bmp_q <= 10'd0;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
            av_q  <= 1'b0;
        end else begin
            div_q <= div_d;
            x_q   <= x_d;
            y_q   <= y_d;
            bmp_q <= bmp_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            av_q  <= av_d;
        end
    end
    // blanking forces address 0 so the memory lookup stays in range
    assign bus.screenAddr  = vis0 ? 11'(row * COLS) + col : 11'd0;
    assign bus.bitmapAddr  = bmp_q;
    assign bus.hsync       = hs_q;
    assign bus.vsync       = vs_q;
    assign bus.activevideo = av_q;
    assign bus.pixel_tick  = tick;
endmodule

// File: doc/vga_screen_scanner.md
Name: vga_screen_scanner

Overview:
- Upstream address generator and timing stage for the tile-based text display.
- Produces 640x480@60 VGA timing from the 100 MHz system clock and drives the 11-bit screen-memory address for the 40x30 grid of 16x16 tiles.
- Accepts the 2-bit character code returned combinationally by screen memory.
- Outputs a registered bitmap address, plus sync and active-video signals delayed to match it, for the downstream bitmap/colour stage.

Parameters:
- CLKDIV, 4, system clocks per pixel (100 MHz -> 25 MHz pixel rate)
- HPIX, 640, visible pixels per line
- HFP, 16, horizontal front porch, pixels
- HSW, 96, hsync pulse width, pixels
- HBP, 48, horizontal back porch, pixels
- VPIX, 480, visible lines
- VFP, 10, vertical front porch, lines
- VSW, 2, vsync pulse width, lines
- VBP, 33, vertical back porch, lines
- COLS, 40, tiles per row (HPIX/16)

Ports:
- clk  in  1  system clock, 100 MHz
- reset  in  1  asynchronous, active-high reset
- characterCode  in  2  tile code from screen memory for the current screenAddr
- screenAddr  out  11  screen-memory address = tile_row*COLS + tile_col
- bitmapAddr  out  10  {characterCode, y[3:0], x[3:0]}, registered
- hsync  out  1  active-low horizontal sync, aligned to bitmapAddr
- vsync  out  1  active-low vertical sync, aligned to bitmapAddr
- activevideo  out  1  high when bitmapAddr refers to a visible pixel
- pixel_tick  out  1  one-clk pulse marking each pixel-rate update

Behaviour:
- Clock divider: 2-bit counter div, 0..CLKDIV-1, wraps to 0.
  - pixel_tick = 1 when div == CLKDIV-1.
  - All stage-0 and stage-1 registers update only on cycles where pixel_tick is 1.
- Stage 0, counters:
  - x runs 0..799 (HPIX+HFP+HSW+HBP-1); at 799 it wraps to 0 and y increments.
  - y runs 0..524; at 524 it wraps to 0 on the same tick that x wraps.
  - x is 10 bits, y is 10 bits.
- Stage 0, decode (combinational from the counters):
  - vis0 = (x < 640) && (y < 480)
  - hs0 = ~(x >= 656 && x <= 751)
  - vs0 = ~(y >= 490 && y <= 491)
- screenAddr (combinational from the counters):
  - When vis0: (y>>4)*40 + (x>>4), implemented as (r<<5)+(r<<3)+c.
  - Range is 0..1199, computed in 11-bit arithmetic with no overflow.
  - When !vis0: forced to 0.
- Screen memory is combinational, so characterCode is valid in the same cycle as screenAddr.
- Stage 1, registered on pixel_tick:
  - bitmapAddr <= {characterCode, y[3:0], x[3:0]}
  - hsync <= hs0, vsync <= vs0, activevideo <= vis0
  - Outputs therefore lag the counters by exactly one pixel (4 clks).
- During blanking, bitmapAddr still registers; its value is don't-care to consumers, but it must be {characterCode for address 0, y[3:0], x[3:0]}.
- Reset (asynchronous, immediate, including mid-frame):
  - div = 0, x = 0, y = 0
  - hsync = 1, vsync = 1, activevideo = 0, bitmapAddr = 0, pixel_tick = 0
  - screenAddr becomes 0 as a direct consequence of x = y = 0.
  - The first pixel_tick occurs 4 clks after reset deasserts.
- No other control inputs. The frame period is exactly 800*525*4 = 1,680,000 clks.

Test Plan:
- Reset mid-frame (x=300, y=200) -> all outputs at reset values in the same cycle; after release, x=0, y=0 and screenAddr=0; first pixel_tick at clk 4.
- Address mapping: x=16,y=0 -> screenAddr=1; x=639,y=479 -> screenAddr=1199; x=0,y=16 -> 40; x=640,y=0 -> 0 (blanking).
- Hsync window: hsync goes low one pixel after x reaches 656 and returns high one pixel after x=752; low for exactly 96 ticks (384 clks); line period is 3200 clks.
- Vsync window: vsync low for exactly 2 lines (6400 clks), starting one pixel after x=0,y=490; frame period is 1,680,000 clks.
- Pipeline alignment: drive characterCode=2'b10 only while screenAddr=41 -> bitmapAddr={2'b10, y[3:0], x[3:0]} with activevideo=1 for tile (1,1) pixels, one pixel late; other tiles carry code 0.
- Wrap: x=799,y=524 tick -> x=0,y=0 on the next tick; activevideo rises one pixel later; no extra or missing line.
